// File: rtl/cpu_register_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_register_write_arbiter
//  Brief    : Round-robin arbiter for the register file's single write port,
//             with registered write port, pending-write mask and write count.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_register_write_arbiter #(
    parameter int NUM_REQUESTERS      = 2,
    parameter int NUMBER_OF_REGISTERS = 16,
    parameter int DATA_WIDTH          = 8,
    parameter int AW                  = $clog2(NUMBER_OF_REGISTERS),
    parameter int PW                  = $clog2(NUM_REQUESTERS)
) (
    input  logic                                 clock_in,
    input  logic                                 reset_in,
    input  logic                                 enable_in,
    input  logic [NUM_REQUESTERS-1:0]            req_valid_in,
    output logic [NUM_REQUESTERS-1:0]            req_ready_out,
    input  logic [NUM_REQUESTERS*AW-1:0]         req_address_in,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data_in,
    output logic                                 write_enable_out,
    output logic [AW-1:0]                        write_register_address_out,
    output logic signed [DATA_WIDTH-1:0]         write_data_out,
    output logic [NUMBER_OF_REGISTERS-1:0]       pending_mask_out,
    output logic [15:0]                          write_count_out,
    output logic [PW-1:0]                        last_grant_out
);

    localparam logic [15:0]   c_count_max = 16'hFFFF;
    localparam logic [PW-1:0] c_last_idx  = PW'(NUM_REQUESTERS - 1);

    logic [PW-1:0]                r_ptr;
    logic [PW-1:0]                r_last_grant;
    logic                         r_write_enable;
    logic [AW-1:0]                r_write_address;
    logic signed [DATA_WIDTH-1:0] r_write_data;
    logic [15:0]                  r_write_count;

    logic [NUM_REQUESTERS-1:0]    w_candidates;
    logic [NUM_REQUESTERS-1:0]    w_ready;
    logic                         w_found;
    logic [PW-1:0]                w_win_idx;
    logic [PW-1:0]                w_next_ptr;
    logic [AW-1:0]                w_win_address;
    logic signed [DATA_WIDTH-1:0] w_win_data;
    logic                         w_issue_write;

    assign w_candidates = req_valid_in & {NUM_REQUESTERS{enable_in & ~reset_in}};

    // Search upward from the pointer, wrapping; the first candidate wins.
    always_comb begin
        int idx;
        idx           = 0;
        w_ready       = '0;
        w_found       = 1'b0;
        w_win_idx     = '0;
        w_win_address = '0;
        w_win_data    = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQUESTERS;
            if (!w_found && w_candidates[idx]) begin
                w_found       = 1'b1;
                w_ready[idx]  = 1'b1;
                w_win_idx     = PW'(idx);
                w_win_address = req_address_in[idx*AW +: AW];
                w_win_data    = req_data_in[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_next_ptr    = (w_win_idx == c_last_idx) ? '0 : w_win_idx + 1'b1;
    // Register 0 is hardwired zero: the request is consumed but never written.
    assign w_issue_write = w_found && (w_win_address != '0);

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_ptr           <= '0;
            r_last_grant    <= '0;
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
            r_write_count   <= '0;
        end else begin
            r_write_enable <= w_issue_write;
            if (w_found) begin
                r_ptr           <= w_next_ptr;
                r_last_grant    <= w_win_idx;
                r_write_address <= w_win_address;
                r_write_data    <= w_win_data;
            end
            if (w_issue_write && (r_write_count != c_count_max)) begin
                r_write_count <= r_write_count + 16'd1;
            end
        end
    end

    always_comb begin
        pending_mask_out = '0;
        if (r_write_enable) begin
            pending_mask_out[r_write_address] = 1'b1;
        end
    end

    assign req_ready_out              = w_ready;
    assign write_enable_out           = r_write_enable;
    assign write_register_address_out = r_write_address;
    assign write_data_out             = r_write_data;
    assign write_count_out            = r_write_count;
    assign last_grant_out             = r_last_grant;

endmodule
`default_nettype wire

// File: tb/tb_cpu_register_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_register_write_arbiter
//  Brief    : Randomized bench with a behavioural write-port model plus
//             directed scenarios pinned by literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_register_write_arbiter;

    localparam int N  = 2;
    localparam int NR = 16;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PW = 1;

    logic                 clock_in = 1'b0;
    logic                 reset_in;
    logic                 enable_in;
    logic [N-1:0]         req_valid_in;
    logic [N-1:0]         req_ready_out;
    logic [N*AW-1:0]      req_address_in;
    logic [N*DW-1:0]      req_data_in;
    logic                 write_enable_out;
    logic [AW-1:0]        write_register_address_out;
    logic signed [DW-1:0] write_data_out;
    logic [NR-1:0]        pending_mask_out;
    logic [15:0]          write_count_out;
    logic [PW-1:0]        last_grant_out;

    cpu_register_write_arbiter #(
        .NUM_REQUESTERS     (N),
        .NUMBER_OF_REGISTERS(NR),
        .DATA_WIDTH         (DW)
    ) dut (
        .clock_in                  (clock_in),
        .reset_in                  (reset_in),
        .enable_in                 (enable_in),
        .req_valid_in              (req_valid_in),
        .req_ready_out             (req_ready_out),
        .req_address_in            (req_address_in),
        .req_data_in               (req_data_in),
        .write_enable_out          (write_enable_out),
        .write_register_address_out(write_register_address_out),
        .write_data_out            (write_data_out),
        .pending_mask_out          (pending_mask_out),
        .write_count_out           (write_count_out),
        .last_grant_out            (last_grant_out)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_ptr, m_last, m_addr, m_data, m_we, m_count;
    logic [N-1:0] seen_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner();
        if (!enable_in || reset_in) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid_in[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_last = 0; m_addr = 0; m_data = 0; m_we = 0; m_count = 0;
    endtask

    task automatic check_outputs();
        logic [31:0] exp_mask;
        exp_mask = m_we ? (32'd1 << m_addr) : 32'd0;
        check("write_enable", {31'd0, write_enable_out}, m_we);
        check("write_addr", {28'd0, write_register_address_out}, m_addr);
        check("write_data", {24'd0, write_data_out}, m_data);
        check("pending_mask", {16'd0, pending_mask_out}, exp_mask);
        check("write_count", {16'd0, write_count_out}, m_count);
        check("last_grant", {31'd0, last_grant_out}, m_last);
    endtask

    // Called just after a falling edge with inputs applied; ends on the next falling edge.
    task automatic cycle(output int gw);
        logic [N-1:0] exp_ready;
        #1;
        gw = model_winner();
        exp_ready = '0;
        if (gw >= 0) exp_ready[gw] = 1'b1;
        seen_ready = req_ready_out;
        check("ready", {30'd0, req_ready_out}, {30'd0, exp_ready});
        @(posedge clock_in);
        if (gw >= 0) begin
            m_ptr  = (gw + 1) % N;
            m_last = gw;
            m_addr = int'(req_address_in[gw*AW +: AW]);
            m_data = int'(req_data_in[gw*DW +: DW]);
            m_we   = (m_addr != 0) ? 1 : 0;
            if (m_we == 1 && m_count < 65535) m_count++;
        end else begin
            m_we = 0;
        end
        #1;
        check_outputs();
        @(negedge clock_in);
    endtask

    task automatic set_req(input int i, input logic v, input int a, input int d);
        req_valid_in[i]           = v;
        req_address_in[i*AW +: AW] = AW'(a);
        req_data_in[i*DW +: DW]    = DW'(d);
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        req_valid_in = '0;
        model_reset();
        @(negedge clock_in);
        @(negedge clock_in);
        reset_in = 1'b0;
    endtask

    initial begin
        int gw;
        int cnt_before;
        reset_in = 1'b1; enable_in = 1'b1;
        req_valid_in = '0; req_address_in = '0; req_data_in = '0;
        model_reset();
        @(negedge clock_in);
        @(negedge clock_in);
        check_outputs();
        check("reset_ready", {30'd0, req_ready_out}, 32'd0);
        reset_in = 1'b0;

        // Single write
        set_req(0, 1'b1, 5, -3);
        cycle(gw);
        check("single_ready", {30'd0, seen_ready}, 32'd1);
        check("single_we", {31'd0, write_enable_out}, 32'd1);
        check("single_addr", {28'd0, write_register_address_out}, 32'd5);
        check("single_data", {24'd0, write_data_out}, 32'hFD);
        check("single_mask", {16'd0, pending_mask_out}, 32'h0020);
        check("single_count", {16'd0, write_count_out}, 32'd1);

        // Round-robin from a fresh pointer
        do_reset();
        set_req(0, 1'b1, 1, 10);
        set_req(1, 1'b1, 2, 20);
        for (int c = 0; c < 4; c++) begin
            cycle(gw);
            check("rr_grant", {30'd0, seen_ready}, (c % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_addr", {28'd0, write_register_address_out}, (c % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_data", {24'd0, write_data_out}, (c % 2 == 0) ? 32'd10 : 32'd20);
        end
        check("rr_last", {31'd0, last_grant_out}, 32'd1);

        // Address-0 write is consumed but dropped
        cnt_before = int'(write_count_out);
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b1, 0, 7);
        cycle(gw);
        check("a0_ready", {30'd0, seen_ready}, 32'd2);
        check("a0_we", {31'd0, write_enable_out}, 32'd0);
        check("a0_mask", {16'd0, pending_mask_out}, 32'd0);
        check("a0_count", {16'd0, write_count_out}, cnt_before);
        set_req(0, 1'b1, 3, 33);
        set_req(1, 1'b1, 4, 44);
        cycle(gw);
        check("a0_next_winner", {30'd0, seen_ready}, 32'd1);

        // Stall
        enable_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle(gw);
            check("stall_ready", {30'd0, seen_ready}, 32'd0);
            check("stall_we", {31'd0, write_enable_out}, 32'd0);
        end
        enable_in = 1'b1;
        cycle(gw);
        check("stall_resume", {30'd0, seen_ready}, 32'd2);

        // Asynchronous reset between edges during continuous grants
        cycle(gw);
        cycle(gw);
        #2;
        reset_in = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("areset_ready", {30'd0, req_ready_out}, 32'd0);
        @(negedge clock_in);
        reset_in = 1'b0;
        cycle(gw);
        check("areset_first", {30'd0, seen_ready}, 32'd1);

        // Randomized traffic; requesters hold until served
        gw = -1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid_in[i] || gw == i) begin
                    set_req(i, ($urandom_range(0, 3) != 0), int'($urandom_range(0, NR - 1)), int'($urandom));
                end
            end
            enable_in = ($urandom_range(0, 7) != 0);
            cycle(gw);
        end

        // Saturation
        enable_in = 1'b1;
        do_reset();
        set_req(0, 1'b1, 9, 1);
        set_req(1, 1'b0, 0, 0);
        for (int c = 0; c < 65536; c++) cycle(gw);
        check("sat_reach", {16'd0, write_count_out}, 32'hFFFF);
        cycle(gw);
        check("sat_hold", {16'd0, write_count_out}, 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
